// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-word pipeline:
// field indices, interrupt pseudo-op default, interrupt FSM encoding.
package ctrl_pkg;

  localparam int CW_RW         = 0;
  localparam int CW_ALU_OR_MEM = 1;
  localparam int CW_MEMWRITE   = 2;
  localparam int CW_BJ         = 13;
  localparam int CW_VGA_WE     = 20;
  localparam int CW_VGA_SEL    = 21;

  localparam logic [35:0] IRQ_CW_DEF = 36'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ISR  = 2'd2
  } irq_state_t;

endpackage

// File: rtl/ctrl_pipe_irq_if.sv
// Decode-side inputs and per-stage outputs of the control pipe.
// The datapath side drives the master modport.
interface ctrl_pipe_irq_if #(
  parameter int CW     = 36,
  parameter int STAGES = 3
);

  logic [CW-1:0]        cw_D;
  logic                 valid_D;
  logic                 bj_taken_D;
  logic                 rti_D;
  logic [STAGES:0]      stall;
  logic [STAGES-1:0]    flush;
  logic                 irq_req;
  logic [STAGES*CW-1:0] cw_out;
  logic [STAGES-1:0]    valid_out;
  logic                 bubble_F;
  logic                 irq_ack;
  logic                 irq_inject;
  logic                 in_isr;

  modport master (
    output cw_D, valid_D, bj_taken_D, rti_D,
    output stall, flush, irq_req,
    input  cw_out, valid_out, bubble_F,
    input  irq_ack, irq_inject, in_isr
  );

  modport slave (
    input  cw_D, valid_D, bj_taken_D, rti_D,
    input  stall, flush, irq_req,
    output cw_out, valid_out, bubble_F,
    output irq_ack, irq_inject, in_isr
  );

endinterface

// File: rtl/ctrl_stage_reg.sv
// One pipeline register for the control word plus its valid bit.
// Invalid entries always hold an all-zero word.
module ctrl_stage_reg #(
  parameter int CW = 36
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          hold,
  input  logic          bub,
  input  logic [CW-1:0] cw_in,
  input  logic          v_in,
  output logic [CW-1:0] cw,
  output logic          valid
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cw    <= '0;
      valid <= 1'b0;
    end else if (!hold) begin
      if (bub) begin
        cw    <= '0;
        valid <= 1'b0;
      end else begin
        cw    <= v_in ? cw_in : '0;
        valid <= v_in;
      end
    end
  end

endmodule

// File: rtl/ctrl_pipe_irq.sv
// Control-word pipe with stall/flush, branch fetch bubbles
// and counter-interrupt entry/return sequencing.
module ctrl_pipe_irq
  import ctrl_pkg::*;
#(
  parameter int              CW         = 36,
  parameter int              STAGES     = 3,
  parameter int              BR_BUBBLES = 1,
  parameter int              BJ_BIT     = CW_BJ,
  parameter logic [CW-1:0]   IRQ_CW     = CW'(IRQ_CW_DEF)
) (
  input logic           clk,
  input logic           reset,
  ctrl_pipe_irq_if.slave bus
);

  logic [CW-1:0] cw_q    [STAGES];
  logic          valid_q [STAGES];
  logic [2:0]    bcnt;
  logic [2:0]    bcnt_n;
  logic          bj_go;
  logic          inject;
  logic          can_inj;
  irq_state_t    st;
  irq_state_t    st_n;

  assign bj_go = bus.valid_D & bus.bj_taken_D & ~bus.stall[0];

  always_comb begin
    bcnt_n = bcnt;
    if (bj_go)
      bcnt_n = 3'(BR_BUBBLES);
    else if (bcnt != 3'd0 && !bus.stall[0])
      bcnt_n = bcnt - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) bcnt <= 3'd0;
    else       bcnt <= bcnt_n;
  end

  // Never separate a branch in stage 1 from its delay slot.
  assign can_inj = ~reset & ~bus.stall[0] & ~bus.stall[1]
                 & ~bus.flush[0] & (bcnt == 3'd0)
                 & ~(bus.valid_D & bus.bj_taken_D)
                 & ~cw_q[0][BJ_BIT];

  always_comb begin
    st_n   = st;
    inject = 1'b0;
    unique case (st)
      IDLE: if (bus.irq_req) st_n = PEND;
      PEND: if (can_inj) begin
        inject = 1'b1;
        st_n   = ISR;
      end
      ISR: if (bus.valid_D & bus.rti_D & ~bus.stall[0])
        st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) st <= IDLE;
    else       st <= st_n;
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_st
    logic [CW-1:0] src_cw;
    logic          src_v;
    if (g == 0) begin : g_first
      assign src_cw = inject ? IRQ_CW : bus.cw_D;
      assign src_v  = inject | bus.valid_D;
    end else begin : g_rest
      assign src_cw = cw_q[g-1];
      assign src_v  = valid_q[g-1];
    end
    ctrl_stage_reg #(.CW(CW)) u_reg (
      .clk   (clk),
      .reset (reset),
      .clr   (bus.flush[g]),
      .hold  (bus.stall[g+1]),
      .bub   (bus.stall[g]),
      .cw_in (src_cw),
      .v_in  (src_v),
      .cw    (cw_q[g]),
      .valid (valid_q[g])
    );
    assign bus.cw_out[g*CW +: CW] = cw_q[g];
    assign bus.valid_out[g]       = valid_q[g];
  end

  assign bus.bubble_F   = (bcnt != 3'd0);
  assign bus.irq_ack    = inject;
  assign bus.irq_inject = inject;
  assign bus.in_isr     = (st == ISR);

endmodule

// File: tb/tb_ctrl_pipe_irq.sv
// Directed and random stimulus for ctrl_pipe_irq against
// a stage-array / counter / flag reference model.
module tb_ctrl_pipe_irq;

  localparam int          CW  = 36;
  localparam int          S   = 3;
  localparam int          BRB = 2;
  localparam int          BJ  = 13;
  localparam logic [CW-1:0] ICW = 36'h8_0000_0041;

  localparam logic [CW-1:0] W0 = 36'h1_2345_6789;
  localparam logic [CW-1:0] W1 = 36'h0_0000_0111;
  localparam logic [CW-1:0] W2 = 36'h0_0000_0222;
  localparam logic [CW-1:0] W3 = 36'h0_0000_0333;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic last_ack;
  logic last_bub;

  logic [CW-1:0] m_w [1:S];
  logic          m_v [1:S];
  int            m_cnt;
  bit            m_pend;
  bit            m_isr;

  ctrl_pipe_irq_if #(.CW(CW), .STAGES(S)) bus ();

  ctrl_pipe_irq #(
    .CW(CW), .STAGES(S), .BR_BUBBLES(BRB),
    .BJ_BIT(BJ), .IRQ_CW(ICW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ok();
    return m_pend && !reset && !bus.stall[0] && !bus.stall[1]
        && !bus.flush[0] && m_cnt == 0
        && !(bus.valid_D && bus.bj_taken_D) && !m_w[1][BJ];
  endfunction

  task automatic model_step();
    bit ok;
    ok = m_ok();
    for (int i = S; i >= 1; i--) begin
      if (reset || bus.flush[i-1]) begin
        m_w[i] = '0;
        m_v[i] = 1'b0;
      end else if (!bus.stall[i]) begin
        if (bus.stall[i-1]) begin
          m_w[i] = '0;
          m_v[i] = 1'b0;
        end else if (i == 1) begin
          m_v[1] = ok || bus.valid_D;
          m_w[1] = ok ? ICW : (bus.valid_D ? bus.cw_D : '0);
        end else begin
          m_w[i] = m_w[i-1];
          m_v[i] = m_v[i-1];
        end
      end
    end
    if (reset)
      m_cnt = 0;
    else if (bus.valid_D && bus.bj_taken_D && !bus.stall[0])
      m_cnt = BRB;
    else if (m_cnt > 0 && !bus.stall[0])
      m_cnt = m_cnt - 1;
    if (reset) begin
      m_pend = 1'b0;
      m_isr  = 1'b0;
    end else if (ok) begin
      m_pend = 1'b0;
      m_isr  = 1'b1;
    end else if (m_isr) begin
      if (bus.valid_D && bus.rti_D && !bus.stall[0]) m_isr = 1'b0;
    end else if (!m_pend && bus.irq_req) begin
      m_pend = 1'b1;
    end
  endtask

  task automatic cyc();
    #1;
    last_ack = bus.irq_ack;
    last_bub = bus.bubble_F;
    for (int i = 1; i <= S; i++) begin
      check($sformatf("cw_s%0d", i),
            64'(bus.cw_out[(i-1)*CW +: CW]), 64'(m_w[i]));
      check($sformatf("valid_s%0d", i),
            64'(bus.valid_out[i-1]), 64'(m_v[i]));
    end
    check("bubble_F", 64'(bus.bubble_F), 64'(m_cnt != 0));
    check("irq_ack", 64'(bus.irq_ack), 64'(m_ok()));
    check("irq_inject", 64'(bus.irq_inject), 64'(m_ok()));
    check("in_isr", 64'(bus.in_isr), 64'(m_isr));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    reset          = 1'b0;
    bus.cw_D       = '0;
    bus.valid_D    = 1'b0;
    bus.bj_taken_D = 1'b0;
    bus.rti_D      = 1'b0;
    bus.stall      = '0;
    bus.flush      = '0;
    bus.irq_req    = 1'b0;
  endtask

  initial begin
    int n;
    logic [S:0] st;
    logic [S-1:0] fl;
    total = 0;
    bad   = 0;
    for (int i = 1; i <= S; i++) begin
      m_w[i] = '0;
      m_v[i] = 1'b0;
    end
    m_cnt  = 0;
    m_pend = 1'b0;
    m_isr  = 1'b0;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_cw", 64'(bus.cw_out), 64'(0));
    check("rst_valid", 64'(bus.valid_out), 64'(0));
    check("rst_bubble", 64'(bus.bubble_F), 64'(0));
    check("rst_isr", 64'(bus.in_isr), 64'(0));
    check("rst_ack", 64'(bus.irq_ack), 64'(0));

    // free run
    bus.valid_D = 1'b1;
    bus.cw_D = W0; cyc();
    bus.cw_D = W1; cyc();
    bus.cw_D = W2; cyc();
    check("run_s3", 64'(bus.cw_out[2*CW +: CW]), 64'(W0));
    check("run_v", 64'(bus.valid_out), 64'(3'b111));

    // hold D and E
    bus.cw_D  = W3;
    bus.stall = 4'b0011;
    cyc(); cyc();
    check("hold_s1", 64'(bus.cw_out[0 +: CW]), 64'(W2));
    check("hold_v2", 64'(bus.valid_out[1]), 64'(0));
    check("hold_v3", 64'(bus.valid_out[2]), 64'(0));
    bus.stall = '0;
    cyc();
    check("rel_s2", 64'(bus.cw_out[CW +: CW]), 64'(W2));
    idle();
    cyc(); cyc(); cyc();

    // taken jump, no stall
    bus.cw_D = W1; bus.valid_D = 1'b1; bus.bj_taken_D = 1'b1;
    cyc();
    idle();
    n = 0;
    repeat (5) begin cyc(); if (last_bub) n++; end
    check("br_bubbles", 64'(n), 64'(BRB));

    // taken jump with one stalled decode cycle
    bus.cw_D = W1; bus.valid_D = 1'b1; bus.bj_taken_D = 1'b1;
    cyc();
    idle();
    n = 0;
    for (int k = 0; k < 6; k++) begin
      bus.stall = (k == 1) ? 4'b0001 : 4'b0000;
      cyc();
      if (last_bub) n++;
    end
    check("br_bubbles_stall", 64'(n), 64'(BRB + 1));
    idle();

    // irq behind a branch in stage 1
    bus.irq_req = 1'b1;
    bus.cw_D = 36'h0_0000_2000; bus.valid_D = 1'b1;
    cyc();
    bus.cw_D = '0; bus.valid_D = 1'b0;
    cyc();
    check("irq_bj_block", 64'(last_ack), 64'(0));
    cyc();
    check("irq_ack1", 64'(last_ack), 64'(1));
    check("irq_s1", 64'(bus.cw_out[0 +: CW]), 64'(ICW));
    check("irq_v1", 64'(bus.valid_out[0]), 64'(1));
    check("irq_isr", 64'(bus.in_isr), 64'(1));

    // level irq ignored in handler, then rti
    n = 0;
    repeat (3) begin cyc(); if (last_ack) n++; end
    check("isr_no_ack", 64'(n), 64'(0));
    bus.cw_D = W1; bus.valid_D = 1'b1; bus.rti_D = 1'b1;
    cyc();
    bus.cw_D = '0; bus.valid_D = 1'b0; bus.rti_D = 1'b0;
    check("rti_idle", 64'(bus.in_isr), 64'(0));
    cyc();
    bus.flush = 3'b001;
    cyc();
    check("flush_no_ack", 64'(last_ack), 64'(0));
    check("flush_s1", 64'(bus.cw_out[0 +: CW]), 64'(0));
    check("flush_isr", 64'(bus.in_isr), 64'(0));
    bus.flush = '0;
    cyc();
    check("irq_ack2", 64'(last_ack), 64'(1));
    check("irq_isr2", 64'(bus.in_isr), 64'(1));

    // reset in handler
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("mid_rst_cw", 64'(bus.cw_out), 64'(0));
    check("mid_rst_v", 64'(bus.valid_out), 64'(0));
    check("mid_rst_isr", 64'(bus.in_isr), 64'(0));
    check("mid_rst_ack", 64'(bus.irq_ack), 64'(0));
    check("mid_rst_bub", 64'(bus.bubble_F), 64'(0));
    idle();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b <= S; b++) st[b] = ($urandom_range(0, 5) == 0);
      for (int b = 0; b < S; b++) fl[b] = ($urandom_range(0, 9) == 0);
      reset          = ($urandom_range(0, 63) == 0);
      bus.stall      = st;
      bus.flush      = fl;
      bus.cw_D       = CW'({$urandom, $urandom});
      bus.valid_D    = ($urandom_range(0, 3) != 0);
      bus.bj_taken_D = ($urandom_range(0, 7) == 0);
      bus.rti_D      = ($urandom_range(0, 11) == 0);
      bus.irq_req    = ($urandom_range(0, 1) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
